scan_mux: RTL and testbench

Parametrised, registered N:1 channel multiplexer with a valid/ready output stage and an optional auto-scan mode. It generalises the 16:1 single-bit select-and-force mux to CHANNELS inputs of WIDTH bits each. It sits between a bank of parallel sample sources and a single downstream consumer. Each captured word is tagged with its source channel, and a force input overrides the captured data to all-ones.

---
 rtl/scan_mux_if.sv | 47 ++++
 rtl/scan_mux.sv | 127 ++++++++++++
 tb/tb_scan_mux.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/scan_mux_if.sv
// scan_mux_if: bundle of the sample-source side and the consumer side of
// scan_mux. The "master" modport is whoever drives the channel bank and the
// control inputs and consumes the output words. The "slave" modport is the
// multiplexer itself.
// Optional feature macro: SCAN_MUX_PARITY_EN adds the out_par signal.
interface scan_mux_if #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          sel;
  logic                      sel_load;
  logic                      mode;
  logic                      en;
  // "force" is a reserved word, hence the longer name
  logic                      force_ones;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
`ifdef SCAN_MUX_PARITY_EN
  logic                      out_par;
`endif

`ifdef SCAN_MUX_PARITY_EN
  modport master (
    output data_in, sel, sel_load, mode, en, force_ones, out_ready,
    input  out_data, out_chan, out_valid, out_par
  );
  modport slave (
    input  data_in, sel, sel_load, mode, en, force_ones, out_ready,
    output out_data, out_chan, out_valid, out_par
  );
`else
  modport master (
    output data_in, sel, sel_load, mode, en, force_ones, out_ready,
    input  out_data, out_chan, out_valid
  );
  modport slave (
    input  data_in, sel, sel_load, mode, en, force_ones, out_ready,
    output out_data, out_chan, out_valid
  );
`endif

endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered CHANNELS:1 multiplexer with a one-word valid/ready
// output stage, a channel pointer that either stays put (direct mode) or
// steps through the channels on every capture (scan mode), and a force input
// that replaces the captured word with all-ones.
// Optional feature macro: SCAN_MUX_PARITY_EN registers the even parity of
// each captured word onto out_par.
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | no word held, out_valid low, next enable captures
// FULL  | word held on out_data/out_chan until accepted
module scan_mux #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1
) (
  input logic       clk,
  input logic       rst,
  scan_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  // Parity of an all-ones word is just the low bit of its width.
  localparam logic FORCE_PAR = 1'(WIDTH % 2);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] ptr_q, ptr_nxt;
  logic             capture;
  logic             sel_ok;
  logic [WIDTH-1:0] chan_word;
  logic [WIDTH-1:0] cap_word;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic             out_valid_q;

  // Compare with one spare bit so a power-of-two CHANNELS does not truncate.
  assign sel_ok = ({1'b0, bus.sel} < (SEL_W + 1)'(CHANNELS));

  // Pick the word of the channel the pointer addresses; codes past the last
  // channel are never reachable but decode to zero for completeness.
  always_comb begin
    chan_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr_q == SEL_W'(k)) begin
        chan_word = bus.data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign cap_word = bus.force_ones ? '1 : chan_word;

  // Next state, capture qualifier and next pointer.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    capture   = bus.en && ((state_q == EMPTY) || bus.out_ready);

    if (capture) begin
      state_nxt = FULL;
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_nxt = EMPTY;
    end

    if (capture && bus.mode) begin
      if (ptr_q == SEL_W'(CHANNELS - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = ptr_q + 1'b1;
      end
    end

    // An explicit load overrides the scan step taken in the same cycle.
    if (bus.sel_load && sel_ok) begin
      ptr_nxt = bus.sel;
    end
  end

  // State, pointer and valid flag; valid is its own flop so the output is
  // not a decode of the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      ptr_q       <= ptr_nxt;
      out_valid_q <= (state_nxt == FULL);
    end
  end

  // Output word and its channel tag, loaded only on a capture so a held
  // word stays frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_chan_q <= '0;
    end else if (capture) begin
      out_data_q <= cap_word;
      out_chan_q <= ptr_q;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

`ifdef SCAN_MUX_PARITY_EN
  logic out_par_q;

  // Parity travels with the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par_q <= 1'b0;
    end else if (capture) begin
      out_par_q <= bus.force_ones ? FORCE_PAR : ^chan_word;
    end
  end

  assign bus.out_par = out_par_q;
`endif

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed checks of scan_mux on two configurations.
//   dut_a: CHANNELS=16, WIDTH=1 (direct-mode single-bit select)
//   dut_b: CHANNELS=10, WIDTH=8 (scan wrap, backpressure, force, sel_load,
//          mode change, enable gating, async reset mid-transfer)
// Channel k of dut_b carries 8'hA0+k so data and channel are distinguishable.
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  scan_mux_if #(.CHANNELS(16), .WIDTH(1)) if_a ();
  scan_mux_if #(.CHANNELS(10), .WIDTH(8)) if_b ();

  scan_mux #(.CHANNELS(16), .WIDTH(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  scan_mux #(.CHANNELS(10), .WIDTH(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct {
    logic       sl;
    logic [3:0] sel;
    logic       mode;
    logic       en;
    logic       frc;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_chan;
    logic       chk_data;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sl sel mode en frc rdy | valid data chan chk
    tbl[0]  = '{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1}; // load 8, no capture
    tbl[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA8, 4'd8, 1'b1};
    tbl[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA9, 4'd9, 1'b1};
    tbl[3]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 4'd0, 1'b1}; // wrapped
    tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 4'd1, 1'b1};
    tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 4'd1, 1'b1}; // stall
    tbl[6]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 4'd1, 1'b1};
    tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 4'd1, 1'b1};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 4'd2, 1'b1}; // released
    tbl[9]  = '{1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 4'd3, 1'b1}; // bad sel
    tbl[10] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 4'd4, 1'b1};
    tbl[11] = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd5, 1'b1}; // load + capture
    tbl[12] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 4'd3, 1'b1};
    tbl[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd4, 1'b1}; // forced
    tbl[14] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd4, 1'b1};
    tbl[15] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd5, 1'b1}; // direct
    tbl[16] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd5, 1'b1};
    tbl[17] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd5, 1'b1}; // force while held
    tbl[18] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd5, 1'b1};
    tbl[19] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0}; // drained
    tbl[20] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd5, 1'b1}; // from EMPTY
    tbl[21] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA6, 4'd6, 1'b1};

    if_a.data_in = '0; if_a.sel = '0; if_a.sel_load = 1'b0; if_a.mode = 1'b0;
    if_a.en = 1'b0; if_a.force_ones = 1'b0; if_a.out_ready = 1'b0;
    if_b.sel = '0; if_b.sel_load = 1'b0; if_b.mode = 1'b0;
    if_b.en = 1'b0; if_b.force_ones = 1'b0; if_b.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) if_b.data_in[k*8 +: 8] = 8'hA0 + 8'(k);

    // reset values
    repeat (2) tick();
    chk("rst_a_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_a_data",  32'(if_a.out_data),  32'd0);
    chk("rst_a_chan",  32'(if_a.out_chan),  32'd0);
    chk("rst_b_valid", 32'(if_b.out_valid), 32'd0);
    chk("rst_b_data",  32'(if_b.out_data),  32'd0);
    chk("rst_b_chan",  32'(if_b.out_chan),  32'd0);
`ifdef SCAN_MUX_PARITY_EN
    chk("rst_b_par",   32'(if_b.out_par),   32'd0);
`endif
    rst = 1'b0;

    // dut_a: direct mode, load channel 5 while capturing from channel 0
    if_a.data_in = 16'h0020; if_a.sel = 4'd5; if_a.sel_load = 1'b1;
    if_a.en = 1'b1; if_a.out_ready = 1'b1;
    tick();
    if_a.sel_load = 1'b0;
    chk("a_first_valid", 32'(if_a.out_valid), 32'd1);
    chk("a_first_chan",  32'(if_a.out_chan),  32'd0);
    chk("a_first_data",  32'(if_a.out_data),  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_valid", 32'(if_a.out_valid), 32'd1);
      chk("a_data",  32'(if_a.out_data),  32'd1);
      chk("a_chan",  32'(if_a.out_chan),  32'd5);
    end
    if_a.en = 1'b0;

    // dut_b: table of per-cycle vectors
    for (int i = 0; i < NV; i++) begin
      if_b.sel_load   = tbl[i].sl;
      if_b.sel        = tbl[i].sel;
      if_b.mode       = tbl[i].mode;
      if_b.en         = tbl[i].en;
      if_b.force_ones = tbl[i].frc;
      if_b.out_ready  = tbl[i].rdy;
      tick();
      chk($sformatf("b_valid[%0d]", i), 32'(if_b.out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].chk_data) begin
        chk($sformatf("b_data[%0d]", i), 32'(if_b.out_data), 32'(tbl[i].exp_data));
        chk($sformatf("b_chan[%0d]", i), 32'(if_b.out_chan), 32'(tbl[i].exp_chan));
`ifdef SCAN_MUX_PARITY_EN
        chk($sformatf("b_par[%0d]", i), 32'(if_b.out_par), 32'(^tbl[i].exp_data));
`endif
      end
    end

    // hold a word under backpressure, then reset asynchronously mid-cycle
    if_b.sel_load = 1'b0; if_b.force_ones = 1'b0; if_b.out_ready = 1'b0;
    if_b.en = 1'b1; if_b.mode = 1'b1;
    tick();
    chk("b_hold_valid", 32'(if_b.out_valid), 32'd1);
    chk("b_hold_chan",  32'(if_b.out_chan),  32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("b_async_valid", 32'(if_b.out_valid), 32'd0);
    chk("b_async_data",  32'(if_b.out_data),  32'd0);
    chk("b_async_chan",  32'(if_b.out_chan),  32'd0);
    tick();
    rst = 1'b0;
    if_b.out_ready = 1'b1;
    tick();
    chk("b_post_rst_valid", 32'(if_b.out_valid), 32'd1);
    chk("b_post_rst_chan",  32'(if_b.out_chan),  32'd0);
    chk("b_post_rst_data",  32'(if_b.out_data),  32'hA0);
    tick();
    chk("b_post_rst_next",  32'(if_b.out_chan),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
